// File: rtl/tile_stream_sequencer.sv
// tile_stream_sequencer: serialises one job into a compute tile's 8-bit switch-word stream and captures its results
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   job_valid/job_ready          job handshake; the job is weight, op, dest and len (operand count)
//   din_valid/din_ready, din     operand handshake, open only while operands are being streamed
//   tx_word                      registered word to the tile's switch input
//   rx_word                      tile's registered switch output
//   res_valid, res_data          one-cycle pulse carrying the raw tile result
//   busy                         high whenever a job is in progress
module tile_stream_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       job_valid,
    output logic       job_ready,
    input  logic [3:0] job_weight,
    input  logic       job_op,
    input  logic [1:0] job_dest,
    input  logic [3:0] job_len,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic [3:0] din,
    output logic [7:0] tx_word,
    input  logic [7:0] rx_word,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, CONFIG, DATA, DRAIN} state_t;
    state_t     state_q, state_d;
    logic [7:0] tx_word_q, tx_word_d, res_data_q, res_data_d;
    logic [3:0] weight_q, weight_d, cnt_q, cnt_d;
    logic [1:0] dest_q, dest_d;
    logic       op_q, op_d, p0_q, p0_d, p1_q, p1_d, res_valid_q, res_valid_d;
    logic       job_acc, din_acc;
    logic [7:0] idle_word;
    assign job_ready = state_q == IDLE;
    assign din_ready = state_q == DATA;
    assign busy      = state_q != IDLE;
    assign job_acc   = job_valid && job_ready;
    assign din_acc   = din_valid && din_ready;
    // Re-sending the current weight leaves the tile's state untouched.
    assign idle_word = {4'h0, weight_q};
    assign tx_word   = tx_word_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    always_comb begin
        state_d     = state_q;
        weight_d    = weight_q;
        op_d        = op_q;
        dest_d      = dest_q;
        cnt_d       = cnt_q;
        tx_word_d   = idle_word;
        // A launched data word comes back from the tile two edges later.
        p0_d        = din_acc;
        p1_d        = p0_q;
        res_valid_d = p1_q;
        res_data_d  = p1_q ? rx_word : res_data_q;
        case (state_q)
            IDLE: if (job_acc) begin
                weight_d  = job_weight;
                op_d      = job_op;
                dest_d    = job_dest;
                cnt_d     = job_len;
                tx_word_d = {4'h0, job_weight};
                state_d   = CONFIG;
            end
            CONFIG: begin
                tx_word_d = {2'b01, dest_q, 3'b000, op_q};
                state_d   = cnt_q != 4'd0 ? DATA : IDLE;
            end
            DATA: if (din_acc) begin
                tx_word_d = {4'h8, din};
                cnt_d     = cnt_q - 4'd1;
                state_d   = cnt_q == 4'd1 ? DRAIN : DATA;
            end
            // Once stage0 is empty, stage1 holds the last result and is captured on this edge.
            DRAIN: state_d = p0_q ? DRAIN : IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_word_q   <= 8'h00;
            weight_q    <= 4'h0;
            op_q        <= 1'b0;
            dest_q      <= 2'b00;
            cnt_q       <= 4'h0;
            p0_q        <= 1'b0;
            p1_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            tx_word_q   <= tx_word_d;
            weight_q    <= weight_d;
            op_q        <= op_d;
            dest_q      <= dest_d;
            cnt_q       <= cnt_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end
endmodule

// File: tb/tb_tile_stream_sequencer.sv
// tb_tile_stream_sequencer: randomized job streams checked cycle by cycle against a timeline model, with a behavioural tile attached
module tb_tile_stream_sequencer;
    logic       clk = 1'b0, rst = 1'b1;
    logic       job_valid = 1'b0, job_ready, job_op = 1'b0;
    logic [3:0] job_weight = 4'h0, job_len = 4'h0, din = 4'h0;
    logic [1:0] job_dest = 2'b00;
    logic       din_valid = 1'b0, din_ready, res_valid, busy;
    logic [7:0] tx_word, rx_word, res_data;
    int n_tests = 0, n_fail = 0;

    tile_stream_sequencer dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_weight(job_weight), .job_op(job_op), .job_dest(job_dest), .job_len(job_len),
        .din_valid(din_valid), .din_ready(din_ready), .din(din), .tx_word(tx_word),
        .rx_word(rx_word), .res_valid(res_valid), .res_data(res_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural compute tile: registers each switch word, answers data words one edge later.
    logic [3:0] tile_w;
    logic       tile_op;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_w <= 4'h0; tile_op <= 1'b0; rx_word <= 8'h00;
        end else if (tx_word[7:6] == 2'b00) tile_w <= tx_word[3:0];
        else if (tx_word[7:6] == 2'b01) tile_op <= tx_word[0];
        else if (tx_word[7:6] == 2'b10)
            rx_word <= tile_op ? 8'h80 + {4'h0, tx_word[3:0]} - {4'h0, tile_w} : {4'h0, tx_word[3:0]} + {4'h0, tile_w};
    end

    logic [3:0] ops[16];
    int         gaps[16];
    int         T;
    logic [7:0] obs_tx[64], obs_rd[64], exp_tx[64], exp_rd[64];
    logic       obs_rv[64], exp_rv[64];
    logic [2:0] obs_st[64], exp_st[64];

    function automatic logic [7:0] tile_res(logic [3:0] w, logic op, logic [3:0] d);
        return op ? 8'h80 + {4'h0, d} - {4'h0, w} : {4'h0, d} + {4'h0, w};
    endfunction

    function automatic string cyc(int k);
        return $sformatf("cycle %0d: got tx=%h rv=%b rd=%h rdy/busy/dinrdy=%b, expected tx=%h rv=%b rd=%h rdy/busy/dinrdy=%b",
                         k, obs_tx[k], obs_rv[k], obs_rd[k], obs_st[k], exp_tx[k], exp_rv[k], exp_rd[k], exp_st[k]);
    endfunction

    // Drives one job (k = cycle after edge A+k, A = accepting edge), builds the expected timeline and records observations.
    task automatic run_job(input logic [3:0] w, input logic op, input logic [1:0] dest, input logic [3:0] len, input bit junk);
        bit         pat[64];
        logic [3:0] pd[64];
        int         ns = 0;
        for (int i = 0; i < int'(len); i++) begin
            for (int g = 0; g < gaps[i]; g++) begin pat[ns] = 0; pd[ns] = 4'($urandom); ns++; end
            pat[ns] = 1; pd[ns] = ops[i]; ns++;
        end
        T = len == 0 ? 2 : ns + 4;
        for (int k = 0; k < T; k++) begin
            exp_tx[k] = {4'h0, w}; exp_rv[k] = 0; exp_rd[k] = 8'h00;
            exp_st[k] = {k == T - 1, k != T - 1, len != 0 && k >= 1 && k <= ns};
        end
        exp_tx[1] = {2'b01, dest, 3'b000, op};
        for (int j = 0; j < ns; j++)
            if (pat[j]) begin
                exp_tx[j + 2] = {4'h8, pd[j]};
                exp_rv[j + 4] = 1;
                exp_rd[j + 4] = tile_res(w, op, pd[j]);
            end
        job_valid = 1; job_weight = w; job_op = op; job_dest = dest; job_len = len;
        @(posedge clk);
        for (int k = 0; k < T; k++) begin
            #1;
            if (len != 0 && k >= 1 && k <= ns) begin din_valid = pat[k - 1]; din = pd[k - 1]; end
            else begin din_valid = junk && $urandom_range(1) == 1; din = 4'($urandom); end
            job_valid = junk && k < T - 1 && $urandom_range(1) == 1;
            job_weight = 4'($urandom); job_op = 1'($urandom); job_dest = 2'($urandom); job_len = 4'($urandom);
            @(negedge clk);
            obs_tx[k] = tx_word; obs_rv[k] = res_valid; obs_rd[k] = res_valid ? res_data : 8'h00;
            obs_st[k] = {job_ready, busy, din_ready};
            if (k < T - 1) @(posedge clk);
        end
        din_valid = 0; job_valid = 0;
    endtask

    task automatic test_reset_state;
        rst = 1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({tx_word, res_valid, res_data, job_ready, busy, din_ready} !== {8'h00, 1'b0, 8'h00, 3'b100}) begin
            n_fail++;
            $display("FAIL reset_state: got tx=%h rv=%b rd=%h rdy/busy/dinrdy=%b%b%b, expected tx=00 rv=0 rd=00 rdy/busy/dinrdy=100",
                     tx_word, res_valid, res_data, job_ready, busy, din_ready);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_add;
        logic [7:0] ref_tx[5] = '{8'h03, 8'h60, 8'h85, 8'h89, 8'h03};
        gaps = '{default: 0}; ops[0] = 4'd5; ops[1] = 4'd9;
        run_job(4'd3, 1'b0, 2'd2, 4'd2, 0);
        for (int k = 0; k < T; k++) begin
            n_tests++;
            if ({obs_tx[k], obs_rv[k], obs_rd[k], obs_st[k]} !== {exp_tx[k], exp_rv[k], exp_rd[k], exp_st[k]}) begin
                n_fail++; $display("FAIL add %s", cyc(k));
            end
        end
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (obs_tx[k] !== ref_tx[k]) begin n_fail++; $display("FAIL add_tx cycle %0d: got %h expected %h", k, obs_tx[k], ref_tx[k]); end
        end
        n_tests++;
        if ({obs_rv[4], obs_rd[4], obs_rv[5], obs_rd[5]} !== {1'b1, 8'h08, 1'b1, 8'h0C}) begin
            n_fail++; $display("FAIL add_results: got %b/%h %b/%h expected 1/08 1/0c", obs_rv[4], obs_rd[4], obs_rv[5], obs_rd[5]);
        end
    endtask

    task automatic test_sub;
        gaps = '{default: 0}; ops[0] = 4'd7;
        run_job(4'd2, 1'b1, 2'd1, 4'd1, 0);
        for (int k = 0; k < T; k++) begin
            n_tests++;
            if ({obs_tx[k], obs_rv[k], obs_rd[k], obs_st[k]} !== {exp_tx[k], exp_rv[k], exp_rd[k], exp_st[k]}) begin
                n_fail++; $display("FAIL sub %s", cyc(k));
            end
        end
        n_tests++;
        if ({obs_tx[0], obs_tx[1], obs_tx[2], obs_rv[4], obs_rd[4], obs_st[4][2]} !== {24'h025187, 1'b1, 8'h85, 1'b1}) begin
            n_fail++; $display("FAIL sub_literal: got tx=%h %h %h rv=%b rd=%h rdy=%b expected tx=02 51 87 rv=1 rd=85 rdy=1",
                               obs_tx[0], obs_tx[1], obs_tx[2], obs_rv[4], obs_rd[4], obs_st[4][2]);
        end
    endtask

    task automatic test_stall;
        int pulses = 0;
        gaps = '{default: 0}; gaps[1] = 2; gaps[2] = 2;
        for (int i = 0; i < 3; i++) ops[i] = 4'($urandom);
        run_job(4'd4, 1'($urandom), 2'($urandom), 4'd3, 1);
        for (int k = 0; k < T; k++) begin
            pulses += int'(obs_rv[k]);
            n_tests++;
            if ({obs_tx[k], obs_rv[k], obs_rd[k], obs_st[k]} !== {exp_tx[k], exp_rv[k], exp_rd[k], exp_st[k]}) begin
                n_fail++; $display("FAIL stall %s", cyc(k));
            end
        end
        n_tests++;
        if (pulses != 3 || obs_tx[3] !== 8'h04 || obs_tx[4] !== 8'h04) begin
            n_fail++; $display("FAIL stall_gaps: got pulses=%0d gap tx=%h %h expected pulses=3 gap tx=04 04", pulses, obs_tx[3], obs_tx[4]);
        end
    endtask

    task automatic test_config_only;
        run_job(4'hF, 1'b1, 2'd3, 4'd0, 1);
        for (int k = 0; k < T; k++) begin
            n_tests++;
            if ({obs_tx[k], obs_rv[k], obs_rd[k], obs_st[k]} !== {exp_tx[k], exp_rv[k], exp_rd[k], exp_st[k]}) begin
                n_fail++; $display("FAIL config_only %s", cyc(k));
            end
        end
        n_tests++;
        if ({obs_tx[0], obs_tx[1]} !== 16'h0F71) begin
            n_fail++; $display("FAIL config_only_tx: got %h %h expected 0f 71", obs_tx[0], obs_tx[1]);
        end
        gaps = '{default: 0}; ops[0] = 4'd6; ops[1] = 4'd1;
        run_job(4'd9, 1'b0, 2'd0, 4'd2, 0);
        for (int k = 0; k < T; k++) begin
            n_tests++;
            if ({obs_tx[k], obs_rv[k], obs_rd[k], obs_st[k]} !== {exp_tx[k], exp_rv[k], exp_rd[k], exp_st[k]}) begin
                n_fail++; $display("FAIL back_to_back %s", cyc(k));
            end
        end
    endtask

    task automatic test_reset_mid_data;
        job_valid = 1; job_weight = 4'd5; job_op = 0; job_dest = 2'd0; job_len = 4'd4;
        @(posedge clk); #1 job_valid = 0;
        @(posedge clk); #1 din_valid = 1; din = 4'd6;
        @(posedge clk); #1 din_valid = 0; rst = 1;
        #1;
        n_tests++;
        if ({tx_word, res_valid, job_ready, busy, din_ready} !== {8'h00, 4'b0100}) begin
            n_fail++; $display("FAIL reset_mid: got tx=%h rv=%b rdy/busy/dinrdy=%b%b%b expected tx=00 rv=0 rdy/busy/dinrdy=100",
                               tx_word, res_valid, job_ready, busy, din_ready);
        end
        @(negedge clk); rst = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if ({res_valid, tx_word, job_ready} !== {1'b0, 8'h00, 1'b1}) begin
                n_fail++; $display("FAIL reset_quiet cycle %0d: got rv=%b tx=%h rdy=%b expected rv=0 tx=00 rdy=1", k, res_valid, tx_word, job_ready);
            end
        end
        gaps = '{default: 0};
        for (int i = 0; i < 4; i++) ops[i] = 4'($urandom);
        run_job(4'($urandom), 1'($urandom), 2'($urandom), 4'd4, 0);
        for (int k = 0; k < T; k++) begin
            n_tests++;
            if ({obs_tx[k], obs_rv[k], obs_rd[k], obs_st[k]} !== {exp_tx[k], exp_rv[k], exp_rd[k], exp_st[k]}) begin
                n_fail++; $display("FAIL after_reset %s", cyc(k));
            end
        end
    endtask

    task automatic test_wrap;
        logic [7:0] want[2] = '{8'h71, 8'h1E};
        for (int t = 0; t < 2; t++) begin
            gaps = '{default: 0}; ops[0] = t == 0 ? 4'd0 : 4'd15;
            run_job(4'd15, t == 0, 2'd0, 4'd1, 0);
            n_tests++;
            if ({obs_rv[4], obs_rd[4]} !== {1'b1, want[t]}) begin
                n_fail++; $display("FAIL wrap %0d: got rv=%b rd=%h expected rv=1 rd=%h", t, obs_rv[4], obs_rd[4], want[t]);
            end
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 16; i++) begin ops[i] = 4'($urandom); gaps[i] = $urandom_range(2); end
            run_job(4'($urandom), 1'($urandom), 2'($urandom), 4'($urandom_range(15)), 1);
            for (int k = 0; k < T; k++) begin
                n_tests++;
                if ({obs_tx[k], obs_rv[k], obs_rd[k], obs_st[k]} !== {exp_tx[k], exp_rv[k], exp_rd[k], exp_st[k]}) begin
                    n_fail++; $display("FAIL random job %0d %s", n, cyc(k));
                end
            end
        end
    endtask

    initial begin
        test_reset_state;
        test_add;
        test_sub;
        test_stall;
        test_config_only;
        test_reset_mid_data;
        test_wrap;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
